multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM that drives the 16-bit datapath's control inputs.
- Consumes the 4-bit opcode (instruction bits 31:28) and returns reg_dst, beq, reg_write, jump, alu_src, mem_to_reg, mem_read, mem_write and alu_op.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and adds a data-memory ready handshake with timeout, single-step run gating, a sticky halt and a retired-instruction counter.

Parameters:
- OP_W, 4: opcode width.
- MEM_TIMEOUT, 15: maximum MEM-state cycles waiting for mem_ready before error halt.
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- clk, input, 1: single clock; all state updates on its rising edge.
- rst_n, input, 1: reset, synchronous, active-low.
- opcode, input, OP_W: instruction opcode from the datapath; sampled only in DECODE.
- run, input, 1: FETCH advances only when high.
- mem_ready, input, 1: data memory has completed the current read or write.
- ir_write, output, 1: latch instruction / start fetch.
- pc_write, output, 1: PC update strobe; high in the final state of every instruction.
- reg_dst, beq, reg_write, jump, alu_src, mem_to_reg, mem_read, mem_write, outputs, 1 each: datapath controls.
- alu_op, output, 2: 00 = add, 01 = subtract/compare, 10 = R-type function.
- halted, output, 1: sticky halt.
- illegal_op, output, 1: sticky; halt caused by an undefined opcode.
- mem_err, output, 1: sticky; halt caused by a mem_ready timeout.
- retired, output, CNT_W: count of completed instructions; saturates at all-ones.

Behaviour:
- Opcode map (shared package): R = 0000, LW = 0001, SW = 0010, BEQ = 0011, ADDI = 0100, J = 0101, HALT = 1111. All other codes are illegal.
- Reset: while rst_n = 0 at a clk edge:
  - state <- RST_S, op_q <- 0, tcnt <- 0, retired <- 0;
  - halted, illegal_op, mem_err <- 0.
  - In RST_S every output is 0; the next state is FETCH.
- Outputs are Moore: they depend only on the state register and op_q, never on the live opcode input. Any control not listed for a state is 0.
- FETCH: ir_write = run. If run = 1, go to DECODE; otherwise stay.
- DECODE: op_q <- opcode.
  - J -> JMP.
  - HALT -> HLT.
  - illegal -> HLT and set illegal_op.
  - all others -> EXEC.
- EXEC:
  - alu_src = 1 for LW, SW, ADDI.
  - reg_dst = 1 for R.
  - alu_op = 10 for R, 01 for BEQ, 00 otherwise.
  - For BEQ: beq = 1 and pc_write = 1, then -> FETCH (instruction retires).
  - LW, SW -> MEM. R, ADDI -> WB.
- MEM: alu_src = 1, alu_op = 00; mem_read = 1 for LW, mem_write = 1 for SW. tcnt increments each cycle.
  - mem_ready = 1 for SW: pc_write = 1, then -> FETCH (retires).
  - mem_ready = 1 for LW: -> WB.
  - No ready and tcnt = MEM_TIMEOUT-1: -> HLT and set mem_err. A ready in that same cycle wins over the timeout.
  - tcnt clears on MEM exit.
- WB: reg_write = 1, pc_write = 1.
  - mem_to_reg = 1 for LW.
  - reg_dst = 1 for R.
  - alu_src = 1 for ADDI; alu_op held as in EXEC.
  - Then -> FETCH (retires).
- JMP: jump = 1, pc_write = 1, then -> FETCH (retires).
- HLT: halted = 1, all datapath controls 0, pc_write = 0. Only reset leaves HLT. HALT itself does not retire.
- retired increments on the edge leaving a retiring state; it holds at 2^CNT_W-1 once reached.
- Latency in cycles, counted from FETCH entry to the next FETCH entry with run held high:
  - J: 3
  - BEQ: 3
  - R, ADDI: 4
  - SW: 3+k
  - LW: 4+k
  - k = MEM cycles, minimum 1.
- Reset mid-instruction: return to RST_S and clear all sticky flags and the counter. No partial write strobes are issued in that cycle, because RST_S drives all outputs to 0.
- Timing rules:
  - mem_read and mem_write are never high together.
  - reg_write and mem_write are never high in the same cycle.
  - pc_write is high at most once per instruction.

Decomposition:
- Shared package ctrl_pkg holds:
  - the opcode localparams;
  - the state enum (RST_S, FETCH, DECODE, EXEC, MEM, WB, JMP, HLT);
  - the alu_op encodings.
- One sub-module, ctrl_decode: a combinational map from (state, op_q) to the control bundle. The top module keeps the state register, op_q, the timeout counter and the retired counter.

Test Plan:
- Reset then R-type: hold rst_n = 0 for 2 cycles, release, run = 1, opcode = 0000.
  - All outputs are 0 during reset.
  - Sequence is FETCH, DECODE, EXEC (alu_op = 10, reg_dst = 1), WB (reg_write = 1, reg_dst = 1, pc_write = 1).
  - retired = 1 after 5 cycles: one cycle in RST_S plus 4.
- LW with mem_ready delayed 3 cycles: mem_read stays high for exactly 3 MEM cycles with alu_src = 1; then WB with mem_to_reg = 1 and reg_write = 1; total 7 cycles from FETCH.
- SW with mem_ready held low for 15 cycles: mem_write is high for 15 cycles, then HLT with halted = 1, mem_err = 1, reg_write never asserted, retired unchanged. Repeat with mem_ready rising on cycle 15: no error, SW retires.
- BEQ then J: BEQ gives beq = 1, alu_op = 01 and pc_write = 1 in EXEC, 3 cycles. J gives jump = 1 and pc_write = 1 in JMP, 3 cycles. retired increments by 2.
- Illegal opcode 1010: DECODE -> HLT with illegal_op = 1 and halted = 1. Opcode changes afterwards have no effect. Pulsing rst_n low for 1 cycle clears all flags and the FETCH sequence restarts.
- run = 0 held 4 cycles in FETCH: ir_write = 0 and the state holds. With run = 1, DECODE on the next edge. Also drive rst_n = 0 during MEM: the next cycle is RST_S with mem_read = 0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: opcode map, FSM states, ALU encodings and control bundle shared by the controller
package ctrl_pkg;
  localparam logic [3:0] OP_R    = 4'h0;
  localparam logic [3:0] OP_LW   = 4'h1;
  localparam logic [3:0] OP_SW   = 4'h2;
  localparam logic [3:0] OP_BEQ  = 4'h3;
  localparam logic [3:0] OP_ADDI = 4'h4;
  localparam logic [3:0] OP_J    = 4'h5;
  localparam logic [3:0] OP_HALT = 4'hF;
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_FN  = 2'b10;
  typedef enum logic [2:0] {RST_S, FETCH, DECODE, EXEC, MEM, WB, JMP, HLT} state_t;
  typedef struct packed {
    logic       ir_write;
    logic       pc_write;
    logic       reg_dst;
    logic       beq;
    logic       reg_write;
    logic       jump;
    logic       alu_src;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] alu_op;
  } ctrl_t;
endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: maps FSM state and latched opcode to the datapath control bundle
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int OP_W = 4
) (
  input  state_t          i_state,
  input  logic [OP_W-1:0] i_op,
  input  logic            i_run,
  input  logic            i_mem_ready,
  output ctrl_t           o_ctrl
);
  logic [3:0] w_op;
  logic w_r, w_lw, w_sw, w_beq, w_addi, w_ex, w_mem, w_wb, w_exwb;
  assign w_op   = 4'(i_op);
  assign w_r    = w_op == OP_R;
  assign w_lw   = w_op == OP_LW;
  assign w_sw   = w_op == OP_SW;
  assign w_beq  = w_op == OP_BEQ;
  assign w_addi = w_op == OP_ADDI;
  assign w_ex   = i_state == EXEC;
  assign w_mem  = i_state == MEM;
  assign w_wb   = i_state == WB;
  assign w_exwb = w_ex || w_wb;
  always_comb begin
    o_ctrl            = '0;
    o_ctrl.ir_write   = i_state == FETCH && i_run;
    o_ctrl.pc_write   = (w_ex && w_beq) || (w_mem && w_sw && i_mem_ready) || w_wb || i_state == JMP;
    o_ctrl.reg_dst    = w_exwb && w_r;
    o_ctrl.beq        = w_ex && w_beq;
    o_ctrl.reg_write  = w_wb;
    o_ctrl.jump       = i_state == JMP;
    o_ctrl.alu_src    = w_mem || (w_ex && (w_lw || w_sw || w_addi)) || (w_wb && w_addi);
    o_ctrl.mem_to_reg = w_wb && w_lw;
    o_ctrl.mem_read   = w_mem && w_lw;
    o_ctrl.mem_write  = w_mem && w_sw;
    o_ctrl.alu_op     = !w_exwb ? ALU_ADD : w_r ? ALU_FN : w_beq ? ALU_SUB : ALU_ADD;
  end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle instruction sequencer with memory handshake timeout, run gating, sticky halt and retire counter
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int OP_W        = 4,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OP_W-1:0]  opcode,
  input  logic             run,
  input  logic             mem_ready,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_dst,
  output logic             beq,
  output logic             reg_write,
  output logic             jump,
  output logic             alu_src,
  output logic             mem_to_reg,
  output logic             mem_read,
  output logic             mem_write,
  output logic [1:0]       alu_op,
  output logic             halted,
  output logic             illegal_op,
  output logic             mem_err,
  output logic [CNT_W-1:0] retired
);
  localparam int TW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TW-1:0] TL = TW'(MEM_TIMEOUT - 1);
  state_t          r_state;
  logic [OP_W-1:0] r_op;
  logic [TW-1:0]   r_tcnt;
  logic [3:0]      w_opc, w_q;
  logic            w_exec;
  ctrl_t           w_ctrl;
  assign w_opc  = 4'(opcode);
  assign w_q    = 4'(r_op);
  assign w_exec = w_opc inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI};
  ctrl_decode #(.OP_W(OP_W)) u_dec (
    .i_state    (r_state),
    .i_op       (r_op),
    .i_run      (run),
    .i_mem_ready(mem_ready),
    .o_ctrl     (w_ctrl)
  );
  assign {ir_write, pc_write, reg_dst, beq, reg_write, jump, alu_src, mem_to_reg,
          mem_read, mem_write, alu_op} = w_ctrl;
  // pc_write marks exactly the final cycle of every retiring instruction
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= RST_S;
      r_op       <= '0;
      r_tcnt     <= '0;
      retired    <= '0;
      halted     <= 1'b0;
      illegal_op <= 1'b0;
      mem_err    <= 1'b0;
    end else begin
      if (w_ctrl.pc_write && !(&retired)) retired <= retired + 1'b1;
      r_tcnt <= (r_state == MEM && !mem_ready && r_tcnt != TL) ? r_tcnt + 1'b1 : '0;
      case (r_state)
        RST_S:  r_state <= FETCH;
        FETCH:  r_state <= run ? DECODE : FETCH;
        DECODE: begin
          r_op       <= opcode;
          r_state    <= w_opc == OP_J ? JMP : w_exec ? EXEC : HLT;
          halted     <= !w_exec && w_opc != OP_J;
          illegal_op <= !w_exec && w_opc != OP_J && w_opc != OP_HALT;
        end
        EXEC:   r_state <= w_q == OP_BEQ ? FETCH : (w_q == OP_LW || w_q == OP_SW) ? MEM : WB;
        MEM: begin
          if (mem_ready) r_state <= w_q == OP_SW ? FETCH : WB;
          else if (r_tcnt == TL) begin
            r_state <= HLT;
            halted  <= 1'b1;
            mem_err <= 1'b1;
          end
        end
        WB, JMP: r_state <= FETCH;
        default: r_state <= r_state;
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: table vectors, directed corner sequences and randomized instruction stream against a latency/strobe model
module tb_multicycle_ctrl;
  import ctrl_pkg::*;
  localparam int CW = 4;
  localparam int MAXR = (1 << CW) - 1;
  logic clk = 1'b0, rst_n, run, mem_ready;
  logic [3:0] opcode;
  logic ir_write, pc_write, reg_dst, beq, reg_write, jump, alu_src, mem_to_reg, mem_read, mem_write;
  logic [1:0] alu_op;
  logic halted, illegal_op, mem_err;
  logic [CW-1:0] retired;
  logic [11:0] w_ctl;
  logic [2:0] w_flg;
  int checks = 0, errors = 0, exp_ret = 0;
  typedef struct {logic rst_n, run; logic [3:0] op; logic [11:0] ctl; logic [2:0] flg; int ret;} vec_t;
  vec_t tbl[27];
  logic [3:0] ops[6];
  always #5 clk = ~clk;
  multicycle_ctrl #(.OP_W(4), .MEM_TIMEOUT(15), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .run(run), .mem_ready(mem_ready),
    .ir_write(ir_write), .pc_write(pc_write), .reg_dst(reg_dst), .beq(beq),
    .reg_write(reg_write), .jump(jump), .alu_src(alu_src), .mem_to_reg(mem_to_reg),
    .mem_read(mem_read), .mem_write(mem_write), .alu_op(alu_op), .halted(halted),
    .illegal_op(illegal_op), .mem_err(mem_err), .retired(retired)
  );
  assign w_ctl = {ir_write, pc_write, reg_dst, beq, reg_write, jump, alu_src, mem_to_reg, mem_read, mem_write, alu_op};
  assign w_flg = {halted, illegal_op, mem_err};
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // one instruction from FETCH entry to the next FETCH entry, checked against latency and strobe totals
  task automatic do_instr(input logic [3:0] op, input int k, input int stall);
    int lat, n_rw, n_mr, n_mw, n_as, n_rd, n_j, n_b, n_m2r, n_sub, n_fn, n_bad;
    lat = (op == OP_J || op == OP_BEQ) ? 3 : op == OP_SW ? 3 + k : op == OP_LW ? 4 + k : 4;
    {n_rw, n_mr, n_mw, n_as, n_rd, n_j, n_b, n_m2r, n_sub, n_fn, n_bad} = '0;
    for (int s = 0; s < stall; s++) begin
      run = 1'b0; opcode = 4'($urandom); mem_ready = 1'($urandom);
      @(negedge clk);
      chk("stall_ir_write", 32'(ir_write), 32'(0));
      step();
    end
    for (int c = 1; c <= lat; c++) begin
      run = c == 1 ? 1'b1 : 1'($urandom);
      opcode = c == 2 ? op : 4'($urandom);
      mem_ready = (c > 3 && c < 3 + k) ? 1'b0 : c == 3 + k ? 1'b1 : 1'($urandom);
      @(negedge clk);
      if (c == 1) chk("retired", 32'(retired), 32'(exp_ret));
      chk($sformatf("ir_write op%0h c%0d", op, c), 32'(ir_write), 32'(c == 1));
      chk($sformatf("pc_write op%0h c%0d", op, c), 32'(pc_write), 32'(c == lat));
      n_rw += int'(reg_write); n_mr += int'(mem_read); n_mw += int'(mem_write);
      n_as += int'(alu_src); n_rd += int'(reg_dst); n_j += int'(jump); n_b += int'(beq);
      n_m2r += int'(mem_to_reg); n_sub += int'(alu_op == 2'b01); n_fn += int'(alu_op == 2'b10);
      n_bad += int'((mem_read && mem_write) || (reg_write && mem_write));
      step();
    end
    exp_ret = exp_ret == MAXR ? MAXR : exp_ret + 1;
    chk("reg_write_cycles", n_rw, int'(op == OP_R || op == OP_ADDI || op == OP_LW));
    chk("mem_read_cycles", n_mr, op == OP_LW ? k : 0);
    chk("mem_write_cycles", n_mw, op == OP_SW ? k : 0);
    chk("alu_src_cycles", n_as, (op == OP_LW || op == OP_SW) ? k + 1 : op == OP_ADDI ? 2 : 0);
    chk("reg_dst_cycles", n_rd, op == OP_R ? 2 : 0);
    chk("jump_cycles", n_j, int'(op == OP_J));
    chk("beq_cycles", n_b, int'(op == OP_BEQ));
    chk("mem_to_reg_cycles", n_m2r, int'(op == OP_LW));
    chk("alu_sub_cycles", n_sub, int'(op == OP_BEQ));
    chk("alu_fn_cycles", n_fn, op == OP_R ? 2 : 0);
    chk("strobe_overlap", n_bad, 0);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n_mw, n_rw;
    ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
    tbl = '{
      '{1'b0, 1'b1, 4'h0, 12'h000, 3'b000, 0}, '{1'b0, 1'b1, 4'h0, 12'h000, 3'b000, 0},
      '{1'b1, 1'b1, 4'h0, 12'h000, 3'b000, 0}, '{1'b1, 1'b1, 4'h0, 12'h800, 3'b000, 0},
      '{1'b1, 1'b1, 4'h0, 12'h000, 3'b000, 0}, '{1'b1, 1'b1, 4'hF, 12'h202, 3'b000, 0},
      '{1'b1, 1'b1, 4'h1, 12'h682, 3'b000, 0}, '{1'b1, 1'b1, 4'h3, 12'h800, 3'b000, 1},
      '{1'b1, 1'b1, 4'h3, 12'h000, 3'b000, 1}, '{1'b1, 1'b1, 4'h0, 12'h501, 3'b000, 1},
      '{1'b1, 1'b1, 4'h5, 12'h800, 3'b000, 2}, '{1'b1, 1'b1, 4'h5, 12'h000, 3'b000, 2},
      '{1'b1, 1'b1, 4'h0, 12'h440, 3'b000, 2}, '{1'b1, 1'b0, 4'h4, 12'h000, 3'b000, 3},
      '{1'b1, 1'b0, 4'h4, 12'h000, 3'b000, 3}, '{1'b1, 1'b0, 4'h4, 12'h000, 3'b000, 3},
      '{1'b1, 1'b0, 4'h4, 12'h000, 3'b000, 3}, '{1'b1, 1'b1, 4'h4, 12'h800, 3'b000, 3},
      '{1'b1, 1'b1, 4'h4, 12'h000, 3'b000, 3}, '{1'b1, 1'b1, 4'h0, 12'h020, 3'b000, 3},
      '{1'b1, 1'b1, 4'h0, 12'h4A0, 3'b000, 3}, '{1'b1, 1'b1, 4'hA, 12'h800, 3'b000, 4},
      '{1'b1, 1'b1, 4'hA, 12'h000, 3'b000, 4}, '{1'b1, 1'b1, 4'h0, 12'h000, 3'b110, 4},
      '{1'b1, 1'b1, 4'h1, 12'h000, 3'b110, 4}, '{1'b0, 1'b1, 4'h1, 12'h000, 3'b110, 4},
      '{1'b1, 1'b1, 4'h0, 12'h000, 3'b000, 0}
    };
    rst_n = 1'b0; run = 1'b0; opcode = 4'h0; mem_ready = 1'b0;
    step();
    for (int i = 0; i < 27; i++) begin
      rst_n = tbl[i].rst_n; run = tbl[i].run; opcode = tbl[i].op; mem_ready = 1'b0;
      @(negedge clk);
      chk($sformatf("tbl%0d ctl", i), 32'(w_ctl), 32'(tbl[i].ctl));
      chk($sformatf("tbl%0d flags", i), 32'(w_flg), 32'(tbl[i].flg));
      chk($sformatf("tbl%0d retired", i), 32'(retired), 32'(tbl[i].ret));
      step();
    end
    exp_ret = 0;
    do_instr(OP_LW, 3, 0);
    do_instr(OP_SW, 15, 0);
    do_instr(OP_BEQ, 1, 1);
    do_instr(OP_J, 1, 0);
    for (int i = 0; i < 30; i++) do_instr(ops[$urandom_range(0, 5)], $urandom_range(1, 4), $urandom_range(0, 2));
    n_mw = 0; n_rw = 0;
    for (int c = 1; c <= 19; c++) begin
      run = 1'b1; opcode = c == 2 ? OP_SW : 4'($urandom); mem_ready = 1'b0;
      @(negedge clk);
      n_mw += int'(mem_write); n_rw += int'(reg_write);
      if (c == 19) begin
        chk("timeout ctl", 32'(w_ctl), 32'(0));
        chk("timeout flags", 32'(w_flg), 32'(3'b101));
        chk("timeout retired", 32'(retired), 32'(exp_ret));
      end
      step();
    end
    chk("timeout mem_write_cycles", n_mw, 15);
    chk("timeout reg_write_cycles", n_rw, 0);
    for (int c = 0; c < 2; c++) begin
      run = 1'b1; mem_ready = 1'b1; opcode = OP_J;
      @(negedge clk);
      chk("hlt sticky flags", 32'(w_flg), 32'(3'b101));
      chk("hlt sticky ctl", 32'(w_ctl), 32'(0));
      step();
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst clears flags", 32'(w_flg), 32'(0));
    chk("rst clears retired", 32'(retired), 32'(0));
    step();
    exp_ret = 0;
    for (int c = 1; c <= 4; c++) begin
      run = 1'b1; opcode = c == 2 ? OP_LW : 4'h0; mem_ready = 1'b0;
      @(negedge clk);
      if (c == 4) chk("mem mem_read", 32'(mem_read), 32'(1));
      step();
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst in mem ctl", 32'(w_ctl), 32'(0));
    step();
    do_instr(OP_R, 1, 0);
    @(negedge clk);
    chk("final retired", 32'(retired), 32'(exp_ret));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
